// File: rtl/node_mem_arbiter_if.sv
// node_mem_arbiter_if: client and memory signal bundle for node_mem_arbiter.
//   req              per-client level read request
//   req_addr         per-client address, client i at [i*ADDR_W +: ADDR_W]
//   grant            one-hot owner of the current transaction
//   rd_valid         one-hot single-cycle pulse, rd_data valid for that client
//   rd_data          returned node word, shared by all clients
//   busy             arbiter is not idle
//   mem_read_address memory read address
//   mem_read_data    memory read data
// Modports: slave (arbiter side), master (clients plus memory side).
interface node_mem_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 272
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_read_address;
    logic [DATA_W-1:0]         mem_read_data;

    modport slave (
        input  req, req_addr, mem_read_data,
        output grant, rd_valid, rd_data, busy, mem_read_address
    );

    modport master (
        output req, req_addr, mem_read_data,
        input  grant, rd_valid, rd_data, busy, mem_read_address
    );
endinterface

// File: rtl/node_mem_arbiter.sv
// node_mem_arbiter: round-robin arbiter and sequencer for the single synchronous read
// port of the determined-nodes memory. One transaction at a time: grant, wait for the
// memory latency, return the word to the owner with a one-cycle rd_valid pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    node_mem_arbiter_if.slave (client handshake and memory read port)
module node_mem_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned DATA_W       = 272,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic                clk,
    input logic                reset,
    node_mem_arbiter_if.slave  bus
);
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LatW = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StWait, StReturn} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]     win_q, win_d;
    logic [LatW-1:0]     lat_q, lat_d;

    logic                found;
    logic [PtrW-1:0]     win_idx;
    int unsigned         idx;

    // First requesting client at or above rr_ptr, wrapping around.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && bus.req[PtrW'(idx)]) begin
                found   = 1'b1;
                win_idx = PtrW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        addr_d     = addr_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        lat_d      = lat_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    addr_d  = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
                    win_d   = win_idx;
                    lat_d   = LatW'(READ_LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - LatW'(1);
                end else begin
                    rd_data_d  = bus.mem_read_data;
                    rd_valid_d = grant_q;
                    state_d    = StReturn;
                end
            end
            StReturn: begin
                grant_d    = '0;
                rd_valid_d = '0;
                rr_ptr_d   = (win_q == PtrW'(NUM_REQ - 1)) ? '0 : win_q + PtrW'(1);
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            addr_q     <= '0;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            addr_q     <= addr_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            lat_q      <= lat_d;
        end
    end

    assign bus.grant            = grant_q;
    assign bus.rd_valid         = rd_valid_q;
    assign bus.rd_data          = rd_data_q;
    assign bus.mem_read_address = addr_q;
    assign bus.busy             = (state_q != StIdle);
endmodule

// File: doc/node_mem_arbiter.md
Name: node_mem_arbiter

Overview:
- Round-robin arbiter and sequencer for the single read port of the determined-nodes memory (7-bit address, 272-bit node_info word, synchronous read).
- Lets up to NUM_REQ pathfinding clients share that port with a req/grant/valid handshake, e.g. the Dijkstra memory reader, the path-traceback unit and the host readback path.
- Owns the memory read_address and returns each 272-bit word only to the client that requested it.

Parameters:
- NUM_REQ, 3, number of requesting clients (2..8).
- ADDR_W, 7, memory address width.
- DATA_W, 272, node_info word width.
- READ_LATENCY, 1, clock edges from the memory sampling read_address to mem_read_data valid (1..4).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- req  in  NUM_REQ  per-client read request, level.
- req_addr  in  NUM_REQ*ADDR_W  per-client address; client i uses bits [i*ADDR_W +: ADDR_W].
- grant  out  NUM_REQ  one-hot, owner of the current transaction.
- rd_valid  out  NUM_REQ  one-hot, one-cycle pulse, rd_data valid for that client.
- rd_data  out  DATA_W  returned node word, shared by all clients.
- busy  out  1  high whenever state != IDLE.
- mem_read_address  out  ADDR_W  drives the memory read_address.
- mem_read_data  in  DATA_W  memory read data (mem_node).

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, grant=0, rd_valid=0, rd_data=0, mem_read_address=0, busy=0.
  - Round-robin pointer rr_ptr=0, latency counter lat_cnt=0.
- FSM states: IDLE, WAIT, RETURN.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - On that edge: grant<=onehot(winner), mem_read_address<=req_addr[winner], lat_cnt<=READ_LATENCY, state<=WAIT.
  - No req high: stay in IDLE; all outputs hold, and mem_read_address keeps its last value.
- WAIT:
  - lat_cnt!=0: lat_cnt<=lat_cnt-1.
  - lat_cnt==0: rd_data<=mem_read_data, rd_valid<=grant, state<=RETURN.
- RETURN:
  - rd_valid and grant are high for exactly this cycle.
  - Next edge: grant<=0, rd_valid<=0, rr_ptr<=(winner+1) mod NUM_REQ, state<=IDLE.
- Latency:
  - With the request high before edge E0 (in IDLE), rd_valid is visible after edge E0+READ_LATENCY+1.
  - With READ_LATENCY=1: E0 grant, E2 rd_valid.
  - Throughput is one transaction every READ_LATENCY+3 cycles.
- rd_data holds its value until the next capture. Clients must take the data on their rd_valid cycle.
- Handshake rules:
  - A client holds req and req_addr stable until it sees its rd_valid.
  - The address is latched at grant, so later req_addr changes do not affect the transaction in flight.
  - A client that keeps req high after rd_valid is re-arbitrated. rr_ptr has already moved past it, so any other pending client wins first.
- Req dropped mid-transaction: the transaction still completes and rd_valid still pulses; the client ignores it. There is no abort.
- Simultaneous requests: exactly one grant, chosen by rr_ptr. No starvation: any client holding req is served within NUM_REQ transactions.
- Reset mid-transaction: immediate return to the reset values. The in-flight transaction is discarded with no rd_valid, and rr_ptr returns to 0.
- grant and rd_valid are never multi-hot. rd_valid is never high outside RETURN.
- Invalid req bits (index >= NUM_REQ) cannot exist. Addresses are passed through unmodified, with no range check.

Test Plan:
- Single request:
  - Stimulus: reset, then req=3'b001, req_addr[0]=7'h17; memory returns its word D17.
  - Response: grant=001 one edge later; mem_read_address=7'h17; rd_valid=001 for 1 cycle, 2 edges after grant; rd_data=D17; busy high for 3 cycles.
- Simultaneous contention:
  - Stimulus: req=3'b111 held with addresses 7'h01, 7'h02, 7'h03.
  - Response: grant order 001, 010, 100, 001, with new grants 4 cycles apart; each rd_data matches that client's address word.
- Round-robin fairness:
  - Stimulus: client 0 holds req continuously; client 2 raises req while client 0's first transaction is in WAIT.
  - Response: the next grant goes to client 2 (100), then back to client 0.
- Request dropped:
  - Stimulus: client 1 requests 7'h40, then drops req during WAIT.
  - Response: rd_valid=010 still pulses with word 7'h40, then return to IDLE; no spurious second grant.
- Asynchronous reset mid-transaction:
  - Stimulus: assert reset (drive 0) during WAIT, between clock edges.
  - Response: grant, rd_valid and busy go to 0 immediately, not at the next edge; after release, req=010 is granted first only if client 0 is idle (rr_ptr=0).
- Latency sweep:
  - Stimulus: READ_LATENCY=3 with a delayed-memory model.
  - Response: rd_valid 4 edges after grant and rd_data correct; no rd_valid earlier.
